// File: rtl/riscmakers_mem_arbiter.sv
// Round-robin arbiter sharing the L1 memory port between icache and dcache.
// One transaction is outstanding at a time; each return is routed to the owner and checked against its TID.
module riscmakers_mem_arbiter #(
    parameter int ADDR_WIDTH = 34,
    parameter int LINE_WIDTH = 128,
    parameter int TID_WIDTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ic_req_i,
    input  logic [ADDR_WIDTH-1:0] ic_addr_i,
    input  logic                  ic_nc_i,
    input  logic [TID_WIDTH-1:0]  ic_tid_i,
    output logic                  ic_ack_o,
    output logic                  ic_rtrn_vld_o,
    input  logic                  dc_req_i,
    input  logic [ADDR_WIDTH-1:0] dc_addr_i,
    input  logic                  dc_we_i,
    input  logic [63:0]           dc_wdata_i,
    input  logic [7:0]            dc_be_i,
    input  logic [2:0]            dc_size_i,
    input  logic                  dc_nc_i,
    input  logic [TID_WIDTH-1:0]  dc_tid_i,
    output logic                  dc_ack_o,
    output logic                  dc_rtrn_vld_o,
    output logic [LINE_WIDTH-1:0] rtrn_data_o,
    output logic                  mem_req_o,
    input  logic                  mem_ack_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [63:0]           mem_wdata_o,
    output logic [7:0]            mem_be_o,
    output logic [2:0]            mem_size_o,
    output logic                  mem_nc_o,
    output logic [TID_WIDTH-1:0]  mem_tid_o,
    input  logic                  mem_rtrn_vld_i,
    input  logic [TID_WIDTH-1:0]  mem_rtrn_tid_i,
    input  logic [LINE_WIDTH-1:0] mem_rtrn_data_i,
    output logic                  busy_o,
    output logic                  stray_o
);

    // state       | meaning
    // S_IDLE      | no owner; grant on any request
    // S_REQ       | owner granted, request presented to memory until ack or abort
    // S_WAIT_RTRN | request accepted, waiting for the return carrying r_tid
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RTRN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC} owner_t;

    state_t                 r_state;
    owner_t                 r_owner;
    logic [TID_WIDTH-1:0]   r_tid;
    logic                   r_last_dc;

    logic                   w_any_req;
    logic                   w_grant_ic;
    logic [TID_WIDTH-1:0]   w_grant_tid;
    logic                   w_owner_req;
    logic                   w_fire;
    logic                   w_rtrn_hit;

    // On a tie the requester that did not win last time is granted.
    assign w_any_req   = ic_req_i | dc_req_i;
    assign w_grant_ic  = ic_req_i & (~dc_req_i | r_last_dc);
    assign w_grant_tid = w_grant_ic ? ic_tid_i : dc_tid_i;
    assign w_owner_req = ((r_owner == OWN_IC) & ic_req_i) | ((r_owner == OWN_DC) & dc_req_i);
    assign w_fire      = (r_state == S_REQ) & w_owner_req & mem_ack_i;
    assign w_rtrn_hit  = (r_state == S_WAIT_RTRN) & mem_rtrn_vld_i & (mem_rtrn_tid_i == r_tid);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_owner   <= OWN_NONE;
            r_tid     <= '0;
            r_last_dc <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_grant_ic ? OWN_IC : OWN_DC;
                        r_tid     <= w_grant_tid;
                        r_last_dc <= ~w_grant_ic;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!w_owner_req) begin
                        r_owner <= OWN_NONE;
                        r_state <= S_IDLE;
                    end else if (mem_ack_i) begin
                        r_state <= S_WAIT_RTRN;
                    end
                end
                S_WAIT_RTRN: begin
                    if (w_rtrn_hit) begin
                        if (w_any_req) begin
                            r_owner   <= w_grant_ic ? OWN_IC : OWN_DC;
                            r_tid     <= w_grant_tid;
                            r_last_dc <= ~w_grant_ic;
                            r_state   <= S_REQ;
                        end else begin
                            r_owner <= OWN_NONE;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_owner <= OWN_NONE;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o     = (r_state == S_REQ) & w_owner_req;
    assign ic_ack_o      = w_fire & (r_owner == OWN_IC);
    assign dc_ack_o      = w_fire & (r_owner == OWN_DC);
    assign ic_rtrn_vld_o = w_rtrn_hit & (r_owner == OWN_IC);
    assign dc_rtrn_vld_o = w_rtrn_hit & (r_owner == OWN_DC);
    assign rtrn_data_o   = mem_rtrn_data_i;
    assign busy_o        = (r_state != S_IDLE);
    assign stray_o       = mem_rtrn_vld_i & ~w_rtrn_hit & ~rst_i;
    assign mem_tid_o     = (r_owner == OWN_NONE) ? '0 : r_tid;

    // Icache only issues reads: full line when cacheable, a single word otherwise.
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        mem_size_o  = '0;
        mem_nc_o    = 1'b0;
        case (r_owner)
            OWN_IC: begin
                mem_addr_o = ic_addr_i;
                mem_nc_o   = ic_nc_i;
                mem_size_o = ic_nc_i ? 3'b010 : 3'b111;
            end
            OWN_DC: begin
                mem_addr_o  = dc_addr_i;
                mem_we_o    = dc_we_i;
                mem_wdata_o = dc_wdata_i;
                mem_be_o    = dc_be_i;
                mem_size_o  = dc_size_i;
                mem_nc_o    = dc_nc_i;
            end
            default: ;
        endcase
    end

endmodule
